// File: rtl/cache_table_axi_rd_slave.sv
// AXI4 read responder serving the hot-entry key/value table from on-chip BRAM.
// Optional range check (SLVERR on out-of-table beats): define CACHE_TBL_ADDR_CHECK_EN.
module cache_table_axi_rd_slave #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 48,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
  parameter int unsigned DEPTH              = 512,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned AR_FIFO_DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic                          tbl_wr_en,
  input  logic [$clog2(DEPTH)-1:0]      tbl_wr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IDW = C_S_AXI_ID_WIDTH;
  localparam int unsigned FPW = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
  localparam int unsigned FCW = $clog2(AR_FIFO_DEPTH + 1);
`ifdef CACHE_TBL_ADDR_CHECK_EN
  localparam bit AddrCheck = 1'b1;
`else
  localparam bit AddrCheck = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // ---------------------------------------------------------------------------
  // AR decode and request FIFO
  // ---------------------------------------------------------------------------
  logic [AW-1:0]  ar_off;
  logic [IW-1:0]  ar_idx;
  logic           ar_oob;
  logic           ar_hs;
  logic           init_q;

  logic [IDW-1:0] af_id_q  [AR_FIFO_DEPTH];
  logic [IW-1:0]  af_idx_q [AR_FIFO_DEPTH];
  logic [7:0]     af_len_q [AR_FIFO_DEPTH];
  logic           af_inc_q [AR_FIFO_DEPTH];
  logic           af_oob_q [AR_FIFO_DEPTH];
  logic [FPW-1:0] af_wptr_q, af_rptr_q;
  logic [FCW-1:0] af_cnt_q;
  logic           af_full, af_empty, af_pop;

  logic unused_bits;
  assign unused_bits = ^{s_axi_arsize, ar_off[2:0]};

  always_comb begin
    ar_off = s_axi_araddr - BASE_ADDR;
    ar_idx = ar_off[IW+2:3];
    // Whole-burst flag for a start beyond the table or below its base
    ar_oob = AddrCheck & ((s_axi_araddr < BASE_ADDR) | (|(ar_off >> (IW + 3))));
  end

  assign af_full       = (af_cnt_q == FCW'(AR_FIFO_DEPTH));
  assign af_empty      = (af_cnt_q == '0);
  assign s_axi_arready = init_q & ~af_full;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
    return (p == FPW'(AR_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      af_id_q[af_wptr_q]  <= s_axi_arid;
      af_idx_q[af_wptr_q] <= ar_idx;
      af_len_q[af_wptr_q] <= s_axi_arlen;
      af_inc_q[af_wptr_q] <= (s_axi_arburst != 2'b00);
      af_oob_q[af_wptr_q] <= ar_oob;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_q    <= 1'b0;
      af_wptr_q <= '0;
      af_rptr_q <= '0;
      af_cnt_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (ar_hs)  af_wptr_q <= ptr_inc(af_wptr_q);
      if (af_pop) af_rptr_q <= ptr_inc(af_rptr_q);
      if (ar_hs && !af_pop)      af_cnt_q <= af_cnt_q + 1'b1;
      else if (!ar_hs && af_pop) af_cnt_q <= af_cnt_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM: one BRAM read per cycle while the output stage has room
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [IW-1:0]  cur_idx_q, cur_idx_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]     cur_len_q, cur_len_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic           cur_inc_q, cur_inc_d;
  logic           cur_oob_q, cur_oob_d;

  logic           in_burst, issue, credit_ok;
  logic [IW-1:0]  src_idx, nxt_idx;
  logic [7:0]     src_cnt, src_len;
  logic [IDW-1:0] src_id;
  logic           src_inc, src_oob, src_last, nxt_oob;

  always_comb begin
    in_burst = (state_q == StBurst);
    // In IDLE the FIFO head is served directly so the first beat costs no extra cycle
    src_idx  = in_burst ? cur_idx_q  : af_idx_q[af_rptr_q];
    src_len  = in_burst ? cur_len_q  : af_len_q[af_rptr_q];
    src_id   = in_burst ? cur_id_q   : af_id_q[af_rptr_q];
    src_inc  = in_burst ? cur_inc_q  : af_inc_q[af_rptr_q];
    src_oob  = in_burst ? cur_oob_q  : af_oob_q[af_rptr_q];
    src_cnt  = in_burst ? beat_cnt_q : 8'd0;
    issue    = (in_burst | ~af_empty) & credit_ok;
    src_last = (src_cnt == src_len);
    nxt_idx  = src_inc ? src_idx + 1'b1 : src_idx;
    nxt_oob  = src_oob | (AddrCheck & src_inc & (src_idx == IW'(DEPTH - 1)));

    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    beat_cnt_d = beat_cnt_q;
    cur_len_d  = cur_len_q;
    cur_id_d   = cur_id_q;
    cur_inc_d  = cur_inc_q;
    cur_oob_d  = cur_oob_q;
    af_pop     = 1'b0;

    if (issue) begin
      if (!in_burst) af_pop = 1'b1;
      if (!src_last) begin
        state_d    = StBurst;
        cur_idx_d  = nxt_idx;
        beat_cnt_d = src_cnt + 8'd1;
        cur_len_d  = src_len;
        cur_id_d   = src_id;
        cur_inc_d  = src_inc;
        cur_oob_d  = nxt_oob;
      end else if (in_burst && !af_empty) begin
        af_pop     = 1'b1;
        state_d    = StBurst;
        cur_idx_d  = af_idx_q[af_rptr_q];
        beat_cnt_d = 8'd0;
        cur_len_d  = af_len_q[af_rptr_q];
        cur_id_d   = af_id_q[af_rptr_q];
        cur_inc_d  = af_inc_q[af_rptr_q];
        cur_oob_d  = af_oob_q[af_rptr_q];
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cur_idx_q  <= '0;
      beat_cnt_q <= '0;
      cur_len_q  <= '0;
      cur_id_q   <= '0;
      cur_inc_q  <= 1'b0;
      cur_oob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      beat_cnt_q <= beat_cnt_d;
      cur_len_q  <= cur_len_d;
      cur_id_q   <= cur_id_d;
      cur_inc_q  <= cur_inc_d;
      cur_oob_q  <= cur_oob_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Table BRAM (read-first) and read pipeline stage
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  rd_q;
  logic           p_vld_q, p_last_q, p_err_q;
  logic [IDW-1:0] p_id_q;

  always_ff @(posedge clk) begin
    if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
    if (issue)     rd_q <= mem[src_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_vld_q  <= 1'b0;
      p_last_q <= 1'b0;
      p_err_q  <= 1'b0;
      p_id_q   <= '0;
    end else begin
      p_vld_q <= issue;
      if (issue) begin
        p_last_q <= src_last;
        p_err_q  <= src_oob;
        p_id_q   <= src_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer; reads are only issued when a slot is guaranteed
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  ob_data_q [2];
  logic [IDW-1:0] ob_id_q   [2];
  logic           ob_last_q [2];
  logic           ob_err_q  [2];
  logic           ob_rptr_q, ob_wslot, ob_pop;
  logic [1:0]     ob_cnt_q, occ;

  assign ob_pop    = s_axi_rvalid & s_axi_rready;
  assign occ       = ob_cnt_q + {1'b0, p_vld_q};
  assign credit_ok = (occ < 2'd2) | ob_pop;
  assign ob_wslot  = ob_rptr_q ^ ob_cnt_q[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        ob_data_q[i] <= '0;
        ob_id_q[i]   <= '0;
        ob_last_q[i] <= 1'b0;
        ob_err_q[i]  <= 1'b0;
      end
      ob_rptr_q <= 1'b0;
      ob_cnt_q  <= '0;
    end else begin
      if (p_vld_q) begin
        ob_data_q[ob_wslot] <= p_err_q ? '0 : rd_q;
        ob_id_q[ob_wslot]   <= p_id_q;
        ob_last_q[ob_wslot] <= p_last_q;
        ob_err_q[ob_wslot]  <= p_err_q;
      end
      if (ob_pop) ob_rptr_q <= ~ob_rptr_q;
      ob_cnt_q <= ob_cnt_q + {1'b0, p_vld_q} - {1'b0, ob_pop};
    end
  end

  assign s_axi_rvalid = (ob_cnt_q != 2'd0);
  assign s_axi_rdata  = ob_data_q[ob_rptr_q];
  assign s_axi_rid    = ob_id_q[ob_rptr_q];
  assign s_axi_rlast  = ob_last_q[ob_rptr_q];
  assign s_axi_rresp  = {ob_err_q[ob_rptr_q], 1'b0};

endmodule
